// File: rtl/ttl_469_sequencer.sv
// Command sequencer for one cascaded 74469 up/down counter: turns LOAD/UP/DOWN/READ
// commands into LD_bar/CBI_bar/OE_bar strobes. Define TTL_469_SHADOW_CHECK_EN for a shadow-compare MISMATCH output.
module ttl_469_sequencer #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 8,
  parameter int SETTLE = 2
) (
  input  logic              CK,
  input  logic              RST_bar,
  input  logic              CMD_VLD,
  output logic              CMD_RDY,
  input  logic [1:0]        CMD_OP,
  input  logic [WIDTH-1:0]  CMD_DATA,
  input  logic [CWIDTH-1:0] CMD_N,
  output logic [WIDTH-1:0]  RDATA,
  output logic              RVALID,
  output logic              WRAP,
  output logic              LD_bar,
  output logic              UD_bar,
  output logic              CBI_bar,
  output logic              OE_bar,
  output logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  Y,
  input  logic              CBO_bar
`ifdef TTL_469_SHADOW_CHECK_EN
  ,
  output logic              MISMATCH
`endif
);

  // state    | meaning
  // IDLE     | CMD_RDY high, waiting for a command
  // LOAD     | LD_bar low for one cycle, A holds the load value
  // STEP     | CBI_bar low for N cycles (high throughout when N=0)
  // SETTLE   | OE_bar low, waiting for Y to become valid
  // CAPTURE  | RDATA just captured, RVALID high, OE_bar released
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state, state_nxt;
  logic [CWIDTH-1:0] rem, rem_nxt;
  logic [SW-1:0]     settle_cnt, settle_cnt_nxt;
  logic              cmd_rdy_nxt;
  logic              ld_bar_nxt;
  logic              ud_bar_nxt;
  logic              cbi_bar_nxt;
  logic              oe_bar_nxt;
  logic [WIDTH-1:0]  a_nxt;
  logic [WIDTH-1:0]  rdata_nxt;
  logic              rvalid_nxt;
  logic              wrap_nxt;
`ifdef TTL_469_SHADOW_CHECK_EN
  logic [WIDTH-1:0]  shadow, shadow_nxt;
  logic              mismatch_nxt;
`endif

  always_ff @(posedge CK) begin
    if (!RST_bar) begin
      state      <= S_IDLE;
      rem        <= '0;
      settle_cnt <= '0;
      CMD_RDY    <= 1'b1;
      LD_bar     <= 1'b1;
      UD_bar     <= 1'b0;
      CBI_bar    <= 1'b1;
      OE_bar     <= 1'b1;
      A          <= '0;
      RDATA      <= '0;
      RVALID     <= 1'b0;
      WRAP       <= 1'b0;
`ifdef TTL_469_SHADOW_CHECK_EN
      shadow     <= '0;
      MISMATCH   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      settle_cnt <= settle_cnt_nxt;
      CMD_RDY    <= cmd_rdy_nxt;
      LD_bar     <= ld_bar_nxt;
      UD_bar     <= ud_bar_nxt;
      CBI_bar    <= cbi_bar_nxt;
      OE_bar     <= oe_bar_nxt;
      A          <= a_nxt;
      RDATA      <= rdata_nxt;
      RVALID     <= rvalid_nxt;
      WRAP       <= wrap_nxt;
`ifdef TTL_469_SHADOW_CHECK_EN
      shadow     <= shadow_nxt;
      MISMATCH   <= mismatch_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    rem_nxt        = rem;
    settle_cnt_nxt = settle_cnt;
    cmd_rdy_nxt    = CMD_RDY;
    ld_bar_nxt     = LD_bar;
    ud_bar_nxt     = UD_bar;
    cbi_bar_nxt    = CBI_bar;
    oe_bar_nxt     = OE_bar;
    a_nxt          = A;
    rdata_nxt      = RDATA;
    rvalid_nxt     = 1'b0;
    wrap_nxt       = WRAP;
`ifdef TTL_469_SHADOW_CHECK_EN
    shadow_nxt     = shadow;
    mismatch_nxt   = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (CMD_VLD && CMD_RDY) begin
          cmd_rdy_nxt = 1'b0;
          case (CMD_OP)
            2'b00: begin
              state_nxt  = S_LOAD;
              ld_bar_nxt = 1'b0;
              a_nxt      = CMD_DATA;
            end
            2'b01, 2'b10: begin
              // N=0 still passes through STEP for one cycle, with CBI_bar kept high
              state_nxt   = S_STEP;
              ud_bar_nxt  = CMD_OP[1];
              wrap_nxt    = 1'b0;
              rem_nxt     = CMD_N;
              cbi_bar_nxt = (CMD_N == '0);
            end
            default: begin
              state_nxt      = S_SETTLE;
              oe_bar_nxt     = 1'b0;
              settle_cnt_nxt = SW'(SETTLE - 1);
            end
          endcase
        end
      end

      S_LOAD: begin
        state_nxt   = S_IDLE;
        ld_bar_nxt  = 1'b1;
        cmd_rdy_nxt = 1'b1;
`ifdef TTL_469_SHADOW_CHECK_EN
        shadow_nxt  = A;
`endif
      end

      S_STEP: begin
        if (!CBO_bar) begin
          wrap_nxt = 1'b1;
        end
`ifdef TTL_469_SHADOW_CHECK_EN
        if (!CBI_bar) begin
          shadow_nxt = UD_bar ? (shadow - WIDTH'(1)) : (shadow + WIDTH'(1));
        end
`endif
        if (rem <= CWIDTH'(1)) begin
          state_nxt   = S_IDLE;
          cbi_bar_nxt = 1'b1;
          cmd_rdy_nxt = 1'b1;
          rem_nxt     = '0;
        end else begin
          rem_nxt = rem - CWIDTH'(1);
        end
      end

      S_SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt    = S_CAPTURE;
          rdata_nxt    = Y;
          rvalid_nxt   = 1'b1;
          oe_bar_nxt   = 1'b1;
`ifdef TTL_469_SHADOW_CHECK_EN
          mismatch_nxt = (Y != shadow);
`endif
        end else begin
          settle_cnt_nxt = settle_cnt - SW'(1);
        end
      end

      S_CAPTURE: begin
        state_nxt   = S_IDLE;
        cmd_rdy_nxt = 1'b1;
      end

      default: begin
        state_nxt   = S_IDLE;
        cmd_rdy_nxt = 1'b1;
        ld_bar_nxt  = 1'b1;
        cbi_bar_nxt = 1'b1;
        oe_bar_nxt  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ttl_469_sequencer.sv
// Bench for ttl_469_sequencer: behavioural 74469 counter on the pins, randomized
// commands checked against an arithmetic model of the counter value and wrap flag.
module tb_ttl_469_sequencer;
  localparam int WIDTH  = 8;
  localparam int CWIDTH = 8;
  localparam int SETTLE = 2;

  logic              CK = 1'b0;
  logic              RST_bar = 1'b0;
  logic              CMD_VLD = 1'b0;
  logic              CMD_RDY;
  logic [1:0]        CMD_OP = 2'b00;
  logic [WIDTH-1:0]  CMD_DATA = '0;
  logic [CWIDTH-1:0] CMD_N = '0;
  logic [WIDTH-1:0]  RDATA;
  logic              RVALID;
  logic              WRAP;
  logic              LD_bar;
  logic              UD_bar;
  logic              CBI_bar;
  logic              OE_bar;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  Y;
  logic              CBO_bar;
`ifdef TTL_469_SHADOW_CHECK_EN
  logic              MISMATCH;
`endif

  ttl_469_sequencer #(.WIDTH(WIDTH), .CWIDTH(CWIDTH), .SETTLE(SETTLE)) dut (
    .CK(CK), .RST_bar(RST_bar), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_N(CMD_N),
    .RDATA(RDATA), .RVALID(RVALID), .WRAP(WRAP),
    .LD_bar(LD_bar), .UD_bar(UD_bar), .CBI_bar(CBI_bar), .OE_bar(OE_bar),
    .A(A), .Y(Y), .CBO_bar(CBO_bar)
`ifdef TTL_469_SHADOW_CHECK_EN
    , .MISMATCH(MISMATCH)
`endif
  );

  always #5 CK = ~CK;

  // Behavioural counter on the other side of the pins; not reset by the sequencer.
  logic [WIDTH-1:0] cnt = '0;
  logic             y_force = 1'b0;
  always @(posedge CK) begin
    if (!LD_bar) cnt <= A;
    else if (!CBI_bar) cnt <= UD_bar ? cnt - 8'd1 : cnt + 8'd1;
  end
  assign CBO_bar = ~(~CBI_bar & (UD_bar ? (cnt == 8'h00) : (cnt == 8'hFF)));
  assign Y = y_force ? 8'hAA : (OE_bar ? ~cnt : cnt);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor
  int   ld_low, cbi_low, oe_low, rv_cnt, mm_cnt, ud_bad, a_bad;
  int   excl_viol = 0;
  logic ud_exp = 1'b0;
  logic [WIDTH-1:0] a_exp = '0;
  always @(negedge CK) begin
    if (!LD_bar) begin
      ld_low++;
      if (A !== a_exp) a_bad++;
    end
    if (!CBI_bar) begin
      cbi_low++;
      if (UD_bar !== ud_exp) ud_bad++;
    end
    if (!OE_bar) oe_low++;
    if (RVALID) rv_cnt++;
`ifdef TTL_469_SHADOW_CHECK_EN
    if (MISMATCH) mm_cnt++;
`endif
    if (int'(!LD_bar) + int'(!CBI_bar) + int'(!OE_bar) > 1) excl_viol++;
  end

  // Reference model state
  logic [WIDTH-1:0] exp_cnt = '0;
  logic [WIDTH-1:0] exp_shadow = '0;
  logic             exp_wrap = 1'b0;

  // Called at a negedge with the sequencer idle; returns at the negedge where CMD_RDY is back.
  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data, input logic [CWIDTH-1:0] n);
    int busy;
    int exp_busy, exp_ld, exp_cbi, exp_oe, exp_rv;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] exp_rdata;
    CMD_VLD = 1'b1; CMD_OP = op; CMD_DATA = data; CMD_N = n;
    ud_exp = (op == 2'b10);
    a_exp  = data;
    busy = 0;
    while (!CMD_RDY && busy < 100) begin @(negedge CK); busy++; end
    check("accept_wait", busy, 0);
    @(posedge CK);
    ld_low = 0; cbi_low = 0; oe_low = 0; rv_cnt = 0; mm_cnt = 0; ud_bad = 0; a_bad = 0;
    @(negedge CK);
    CMD_VLD  = 1'b0;
    CMD_OP   = 2'($urandom_range(0, 3));
    CMD_DATA = 8'($urandom);
    CMD_N    = 8'($urandom);
    busy = 0;
    while (!CMD_RDY && busy < 400) begin busy++; @(negedge CK); end

    exp_ld = 0; exp_cbi = 0; exp_oe = 0; exp_rv = 0; exp_rdata = RDATA;
    case (op)
      2'b00: begin
        exp_busy = 1; exp_ld = 1;
        exp_cnt = data; exp_shadow = data;
      end
      2'b01: begin
        exp_busy = (n == 0) ? 1 : int'(n); exp_cbi = int'(n);
        sum = {1'b0, exp_cnt} + {1'b0, n};
        exp_wrap = sum[WIDTH];
        exp_cnt = sum[WIDTH-1:0]; exp_shadow = exp_shadow + n;
      end
      2'b10: begin
        exp_busy = (n == 0) ? 1 : int'(n); exp_cbi = int'(n);
        exp_wrap = (n > exp_cnt);
        exp_cnt = exp_cnt - n; exp_shadow = exp_shadow - n;
      end
      default: begin
        exp_busy = SETTLE + 1; exp_oe = SETTLE; exp_rv = 1;
        exp_rdata = y_force ? 8'hAA : exp_cnt;
      end
    endcase

    check("busy_cycles", busy, exp_busy);
    check("ld_low_cycles", ld_low, exp_ld);
    check("cbi_low_cycles", cbi_low, exp_cbi);
    check("oe_low_cycles", oe_low, exp_oe);
    check("rvalid_pulses", rv_cnt, exp_rv);
    check("wrap", WRAP, exp_wrap);
    check("ud_during_step", ud_bad, 0);
    check("a_during_load", a_bad, 0);
    if (op == 2'b11) begin
      check("rdata", RDATA, exp_rdata);
`ifdef TTL_469_SHADOW_CHECK_EN
      check("mismatch_pulses", mm_cnt, (exp_rdata != exp_shadow) ? 1 : 0);
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CK);
    @(negedge CK);
    check("rst_cmd_rdy", CMD_RDY, 1);
    check("rst_ld_bar", LD_bar, 1);
    check("rst_ud_bar", UD_bar, 0);
    check("rst_cbi_bar", CBI_bar, 1);
    check("rst_oe_bar", OE_bar, 1);
    check("rst_a", A, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_wrap", WRAP, 0);
`ifdef TTL_469_SHADOW_CHECK_EN
    check("rst_mismatch", MISMATCH, 0);
`endif
    RST_bar = 1'b1;
    @(negedge CK);

    // Directed cases
    run_cmd(2'b00, 8'h3C, 8'd0);
    run_cmd(2'b11, 8'h00, 8'd0);
    run_cmd(2'b00, 8'hFD, 8'd0);
    run_cmd(2'b01, 8'h00, 8'd5);
    run_cmd(2'b11, 8'h00, 8'd0);
    run_cmd(2'b00, 8'h03, 8'd0);
    run_cmd(2'b10, 8'h00, 8'd3);
    run_cmd(2'b11, 8'h00, 8'd0);
    run_cmd(2'b10, 8'h00, 8'd1);
    run_cmd(2'b11, 8'h00, 8'd0);
    run_cmd(2'b01, 8'h00, 8'd0);
    run_cmd(2'b11, 8'h00, 8'd0);

    // Randomized command stream
    for (int i = 0; i < 60; i++) begin
      logic [1:0]        op;
      logic [WIDTH-1:0]  d;
      logic [CWIDTH-1:0] n;
      op = 2'($urandom_range(0, 3));
      d  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      n  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      run_cmd(op, d, n);
      if ($urandom_range(0, 2) == 0) run_cmd(2'b11, 8'h00, 8'd0);
    end

    // Reset during the 3rd STEP cycle of UP N=10
    CMD_VLD = 1'b1; CMD_OP = 2'b01; CMD_N = 8'd10; ud_exp = 1'b0;
    @(posedge CK);
    @(negedge CK); CMD_VLD = 1'b0;
    @(negedge CK);
    @(negedge CK); RST_bar = 1'b0;
    @(negedge CK);
    check("midrst_cbi_bar", CBI_bar, 1);
    check("midrst_cmd_rdy", CMD_RDY, 1);
    check("midrst_wrap", WRAP, 0);
    RST_bar = 1'b1;
    exp_cnt = exp_cnt + 8'd3;
    exp_shadow = '0;
    exp_wrap = 1'b0;
    @(negedge CK);
    run_cmd(2'b11, 8'h00, 8'd0);

    // Bus value differs from the tracked value at capture
    run_cmd(2'b00, 8'h10, 8'd0);
    y_force = 1'b1;
    run_cmd(2'b11, 8'h00, 8'd0);
    y_force = 1'b0;
    run_cmd(2'b11, 8'h00, 8'd0);

    check("mutual_exclusion", excl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ttl_469_sequencer.md
Name: ttl_469_sequencer

Overview:
- Command-driven initiator for one cascaded ttl_74469 up/down counter stage.
- Converts single-handshake commands into counter control strobes: LOAD, step up N, step down N, READ.
- Drives LD_bar, UD_bar, CBI_bar, OE_bar and A. Samples the tri-state Y bus and CBO_bar.
- Sits between the microsequencer and the address/PC counter, so control logic never has to time counter strobes itself.

Parameters:
- WIDTH, 8, counter data width (A, Y, CMD_DATA, RDATA).
- CWIDTH, 8, width of the step-count field CMD_N.
- SETTLE, 2, OE_bar-low cycles before Y is captured (≥1). Covers the counter's 15 ns output delay.

Ports:
- CK  input  1  rising-edge clock
- RST_bar  input  1  synchronous active-low reset
- CMD_VLD  input  1  command valid
- CMD_RDY  output  1  sequencer idle, able to accept a command
- CMD_OP  input  2  00 LOAD, 01 UP, 10 DOWN, 11 READ
- CMD_DATA  input  WIDTH  load value for LOAD
- CMD_N  input  CWIDTH  step count for UP/DOWN
- RDATA  output  WIDTH  last captured Y value
- RVALID  output  1  one-cycle pulse: RDATA updated
- WRAP  output  1  sticky: counter wrapped during last UP/DOWN
- LD_bar  output  1  to counter LD_bar
- UD_bar  output  1  to counter UD_bar (0 up, 1 down)
- CBI_bar  output  1  to counter CBI_bar
- OE_bar  output  1  to counter OE_bar
- A  output  WIDTH  to counter A
- Y  input  WIDTH  from counter Y (may be high-Z when OE_bar high)
- CBO_bar  input  1  from counter CBO_bar

Behaviour:
- One clock (CK). Reset is synchronous and active-low (RST_bar). All outputs are registered.
- Reset values: IDLE state, CMD_RDY=1, LD_bar=1, UD_bar=0, CBI_bar=1, OE_bar=1, A=0, RDATA=0, RVALID=0, WRAP=0.
- States: IDLE, LOAD, STEP, SETTLE, CAPTURE.
- IDLE:
  - CMD_RDY=1.
  - A command is accepted on the edge where CMD_VLD=1 and CMD_RDY=1. Its fields are latched and CMD_RDY drops on the same edge.
  - Accepting UP or DOWN clears WRAP.
- LOAD:
  - Exactly one cycle with LD_bar=0 and A=latched data. The counter loads on the edge ending this cycle.
  - Next state IDLE, with LD_bar=1.
- UP/DOWN with N=0: returns to IDLE next cycle. No CBI_bar pulse. WRAP stays 0.
- STEP (N≥1):
  - CBI_bar=0 for exactly N consecutive cycles.
  - UD_bar is set on acceptance (0 for UP, 1 for DOWN) and held stable through all of STEP.
  - An internal remaining-count register decrements each cycle. On the final cycle CBI_bar returns to 1 and the state goes to IDLE.
  - Net effect: counter changes by exactly N modulo 2^WIDTH.
- WRAP detection: if CBO_bar is sampled 0 at any STEP-cycle edge, WRAP is set. This means the counter passes all-ones going up, or all-zeros going down, on that edge. WRAP is held until the next UP/DOWN is accepted or reset.
- READ:
  - SETTLE state: OE_bar=0 for SETTLE cycles.
  - CAPTURE is one cycle: RDATA<=Y, RVALID=1 for that cycle, OE_bar returns to 1, then IDLE.
  - OE_bar is never 0 outside SETTLE/CAPTURE.
- Mutual exclusion: LD_bar=0, CBI_bar=0 and OE_bar=0 are never asserted in the same cycle.
- Back-to-back: a new command can be accepted in the first IDLE cycle after any command completes. There are no idle bubbles beyond that.
- Reset mid-operation:
  - Outputs return to reset values on the first edge with RST_bar=0.
  - The counter still sees the pre-reset CBI_bar/LD_bar on that same edge, so one extra step or load can occur. This is accepted.
  - The counter itself is not reset by this block.
- CMD_OP/CMD_DATA/CMD_N changes while CMD_RDY=0 are ignored.

Optional Feature:
- Macro: TTL_469_SHADOW_CHECK_EN.
- With the macro defined:
  - A WIDTH-bit shadow register tracks the expected counter value. LOAD sets it to the data; each STEP cycle adds or subtracts 1 with wrap.
  - CAPTURE compares Y to the shadow value.
  - An extra output MISMATCH (1 bit) pulses with RVALID when they differ.
  - MISMATCH resets to 0.
  - The shadow register resets to 0, matching the counter's power-up value.
- Without the macro: no shadow register and no MISMATCH port. Behaviour is otherwise identical.

Test Plan:
- Reset, then LOAD 8'h3C followed by READ -> exactly one LD_bar low cycle with A=8'h3C. After SETTLE+1 cycles RDATA=8'h3C and RVALID pulses once.
- LOAD 8'hFD, UP N=5, READ -> CBI_bar low exactly 5 cycles with UD_bar=0. WRAP=1. RDATA=8'h02.
- LOAD 8'h03, DOWN N=3, READ -> RDATA=8'h00, WRAP=0. Then DOWN N=1, READ -> WRAP=1, RDATA=8'hFF.
- UP N=0 -> CMD_RDY returns high one cycle after acceptance. CBI_bar never low. Counter value unchanged on READ.
- RST_bar low during the 3rd cycle of UP N=10 -> CBI_bar=1 and CMD_RDY=1 after that edge. Counter has advanced by 3.
- With TTL_469_SHADOW_CHECK_EN defined, a bench forces Y=8'hAA while the shadow value is 8'h10 at CAPTURE -> MISMATCH=1 for one cycle together with RVALID. Without the macro the bench compiles without the MISMATCH port.
